// File: rtl/trans_pose_sched.sv
// Pose-bank scheduler for the 3x4 transform datapath: double-buffered pose with drain-before-swap.
// Latency: point 1 cycle to o_tm_*; commit to swap pulse PIPE_LAT+2 cycles. Backpressure: o_ready/o_pose_wr_ready low in DRAIN/SWAP.
// Build option TRANS_POSE_SCHED_IDENT_INIT_EN: both banks reset to the identity pose instead of zeros.
module trans_pose_sched #(
    parameter int POSE_WORDS = 12,
    parameter int PIPE_LAT   = 3,
    parameter int CNT_BW     = 20,
    parameter int CLOUD_BW   = 16,
    parameter int POSE_BW    = 32,
    parameter int MUL        = 16
) (
    input  logic                                i_clk,
    input  logic                                i_rst_n,
    input  logic                                i_valid,
    output logic                                o_ready,
    input  logic [CLOUD_BW-1:0]                 i_cloud_x,
    input  logic [CLOUD_BW-1:0]                 i_cloud_y,
    input  logic [CLOUD_BW-1:0]                 i_cloud_z,
    output logic                                o_tm_valid,
    output logic [CLOUD_BW-1:0]                 o_tm_cloud_x,
    output logic [CLOUD_BW-1:0]                 o_tm_cloud_y,
    output logic [CLOUD_BW-1:0]                 o_tm_cloud_z,
    output logic [POSE_WORDS-1:0][POSE_BW-1:0]  o_pose,
    input  logic                                i_pose_wr_valid,
    output logic                                o_pose_wr_ready,
    input  logic [3:0]                          i_pose_wr_idx,
    input  logic [POSE_BW-1:0]                  i_pose_wr_data,
    input  logic                                i_pose_commit,
    output logic                                o_pose_swapped,
    output logic                                o_pose_err,
    output logic [CNT_BW-1:0]                   o_beat_cnt
);
    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_SWAP} state_t;
    typedef logic [POSE_WORDS-1:0][POSE_BW-1:0] bank_t;

    localparam int         DW      = $clog2(PIPE_LAT + 2);
    localparam logic [3:0] IDX_LIM = 4'(POSE_WORDS);

    function automatic bank_t reset_bank();
        bank_t b;
        b = '0;
`ifdef TRANS_POSE_SCHED_IDENT_INIT_EN
        b[0]  = POSE_BW'(1) << MUL;
        b[5]  = POSE_BW'(1) << MUL;
        b[10] = POSE_BW'(1) << MUL;
`endif
        return b;
    endfunction

    state_t              state_q, state_d;
    logic [DW-1:0]       drain_q, drain_d;
    logic                tm_vld_q, tm_vld_d;
    logic [CLOUD_BW-1:0] tm_x_q, tm_x_d, tm_y_q, tm_y_d, tm_z_q, tm_z_d;
    bank_t               active_q, active_d, shadow_q, shadow_d;
    logic                swapped_q, swapped_d;
    logic                err_q, err_d;
    logic [CNT_BW-1:0]   beat_q, beat_d;
    logic                accept, wr_accept;

    assign o_ready         = (state_q == ST_RUN) & i_rst_n;
    assign o_pose_wr_ready = (state_q == ST_RUN) & i_rst_n;
    assign accept          = i_valid & o_ready;
    assign wr_accept       = i_pose_wr_valid & o_pose_wr_ready;

    always_comb begin
        state_d   = state_q;
        drain_d   = drain_q;
        tm_vld_d  = accept;
        tm_x_d    = tm_x_q;
        tm_y_d    = tm_y_q;
        tm_z_d    = tm_z_q;
        active_d  = active_q;
        shadow_d  = shadow_q;
        swapped_d = 1'b0;
        err_d     = err_q;
        beat_d    = beat_q;

        if (accept) begin
            tm_x_d = i_cloud_x;
            tm_y_d = i_cloud_y;
            tm_z_d = i_cloud_z;
            beat_d = beat_q + CNT_BW'(1);
        end

        if (wr_accept) begin
            if (i_pose_wr_idx < IDX_LIM) begin
                shadow_d[i_pose_wr_idx] = i_pose_wr_data;
            end else begin
                err_d = 1'b1;
            end
        end

        case (state_q)
            ST_RUN: begin
                if (i_pose_commit) begin
                    state_d = ST_DRAIN;
                    drain_d = DW'(PIPE_LAT + 1);
                end
            end
            ST_DRAIN: begin
                drain_d = drain_q - DW'(1);
                // Swap lands on the edge the counter reaches zero, so the pulse and new bank appear together.
                if (drain_q == DW'(1)) begin
                    state_d   = ST_SWAP;
                    active_d  = shadow_q;
                    swapped_d = 1'b1;
                    beat_d    = '0;
                end
            end
            ST_SWAP: state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= ST_RUN;
            drain_q   <= '0;
            tm_vld_q  <= 1'b0;
            tm_x_q    <= '0;
            tm_y_q    <= '0;
            tm_z_q    <= '0;
            active_q  <= reset_bank();
            shadow_q  <= reset_bank();
            swapped_q <= 1'b0;
            err_q     <= 1'b0;
            beat_q    <= '0;
        end else begin
            state_q   <= state_d;
            drain_q   <= drain_d;
            tm_vld_q  <= tm_vld_d;
            tm_x_q    <= tm_x_d;
            tm_y_q    <= tm_y_d;
            tm_z_q    <= tm_z_d;
            active_q  <= active_d;
            shadow_q  <= shadow_d;
            swapped_q <= swapped_d;
            err_q     <= err_d;
            beat_q    <= beat_d;
        end
    end

    assign o_tm_valid     = tm_vld_q;
    assign o_tm_cloud_x   = tm_x_q;
    assign o_tm_cloud_y   = tm_y_q;
    assign o_tm_cloud_z   = tm_z_q;
    assign o_pose         = active_q;
    assign o_pose_swapped = swapped_q;
    assign o_pose_err     = err_q;
    assign o_beat_cnt     = beat_q;
endmodule
